tli4970_array: RTL and testbench

Polls NUM_CH TLI4970 current sensors sharing one SPI clock and MISO line, each with its own chip select. Runs a full sweep over all channels at a programmable update period, decodes each 16-bit frame into data or status, checks parity and publishes per-channel current words with valid strobes. Sits between the sensor pins and the motor-control register file, replacing the single-channel readout.

---
 rtl/tli4970_pkg.sv | 30 +++
 rtl/tli4970_if.sv | 11 +
 rtl/tli4970_spi_rx16.sv | 72 +++++++
 rtl/tli4970_array.sv | 172 +++++++++++++++++
 tb/tb_tli4970_array.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tli4970_pkg.sv
// Shared definitions for the TLI4970 multi-sensor readout: frame layout,
// current offset, sweep FSM encoding and frame helpers.
package tli4970_pkg;

  localparam int FRAME_W          = 16;
  localparam int FRAME_TYPE_BIT   = 15;
  localparam int FRAME_PARITY_BIT = 14;
  localparam int CURRENT_W        = 13;
  localparam logic [CURRENT_W-1:0] CURRENT_OFFSET = 13'd4096;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECT   = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_DESELECT = 2'd3
  } state_t;

  // Bit 14 makes the whole frame even-weight when the sensor sent it intact.
  function automatic logic frame_parity_ok(input logic [FRAME_W-1:0] frame);
    return ~^frame;
  endfunction

  function automatic logic [CURRENT_W-1:0] decode_current(
      input logic [FRAME_W-1:0] frame, input logic signed_out);
    logic [CURRENT_W-1:0] raw;
    raw = frame[CURRENT_W-1:0];
    return signed_out ? (raw - CURRENT_OFFSET) : raw;
  endfunction

endpackage

// File: rtl/tli4970_if.sv
// Sensor-side SPI pins: shared SCK and MISO, one active-low chip select per sensor.
interface tli4970_if #(
  parameter int NUM_CH = 4
);
  logic              spi_clk;
  logic [NUM_CH-1:0] spi_cs;
  logic              spi_miso;

  modport master (output spi_clk, output spi_cs, input  spi_miso);
  modport slave  (input  spi_clk, input  spi_cs, output spi_miso);
endinterface

// File: rtl/tli4970_spi_rx16.sv
// Half-period divider, SCK generator and 16-bit MSB-first receiver.
// MISO is captured on the clk edge where SCK falls.
module spi_rx16
  import tli4970_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_div_en,
  input  logic               i_sck_en,
  input  logic               i_miso,
  output logic               o_half_tick,
  output logic               o_sck,
  output logic               o_bits_done,
  output logic               o_frame_done,
  output logic [FRAME_W-1:0] o_frame
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0]   r_div;
  logic               r_sck;
  logic [4:0]         r_cnt;
  logic [FRAME_W-1:0] r_sr;
  logic               r_done;
  logic               w_half_tick;

  assign w_half_tick = i_div_en && (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (!i_div_en || w_half_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // r_cnt counts completed bits; SCK is not raised again once all 16 are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck  <= 1'b0;
      r_cnt  <= '0;
      r_sr   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!i_sck_en) begin
        r_sck <= 1'b0;
        r_cnt <= '0;
      end else if (w_half_tick) begin
        if (r_sck) begin
          r_sck  <= 1'b0;
          r_sr   <= {r_sr[FRAME_W-2:0], i_miso};
          r_cnt  <= r_cnt + 5'd1;
          r_done <= (r_cnt == 5'(FRAME_W - 1));
        end else if (r_cnt != 5'(FRAME_W)) begin
          r_sck <= 1'b1;
        end
      end
    end
  end

  assign o_half_tick  = w_half_tick;
  assign o_sck        = r_sck;
  assign o_bits_done  = (r_cnt == 5'(FRAME_W));
  assign o_frame_done = r_done;
  assign o_frame      = r_sr;

endmodule

// File: rtl/tli4970_array.sv
// Periodic sweep over NUM_CH TLI4970 sensors on a shared SPI bus; decodes each
// frame into a per-channel current or status word with parity checking.
module tli4970_array
  import tli4970_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CLK_DIV       = 8,
  parameter int UPDATE_PERIOD = 10000,
  parameter int CS_GAP        = 2,
  parameter int SIGNED_OUT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_clear_flags,
  tli4970_if.master             spi,
  output logic [13*NUM_CH-1:0]  o_current,
  output logic [NUM_CH-1:0]     o_current_valid,
  output logic [16*NUM_CH-1:0]  o_status_word,
  output logic [NUM_CH-1:0]     o_status_valid,
  output logic [NUM_CH-1:0]     o_parity_err,
  output logic                  o_overrun
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PER_W = $clog2(UPDATE_PERIOD + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  state_t             r_state, w_state_next;
  logic [CH_W-1:0]    r_ch, w_ch_next;
  logic [GAP_W-1:0]   r_gap, w_gap_next;
  logic [PER_W-1:0]   r_period;
  logic               r_overrun;
  logic               w_tick, w_half_tick, w_bits_done, w_frame_done;
  logic               w_selected, w_parity_ok;
  logic [FRAME_W-1:0] w_frame;
  logic [NUM_CH-1:0]  w_cs;

  spi_rx16 #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .i_div_en     (r_state != ST_IDLE),
    .i_sck_en     (w_selected),
    .i_miso       (spi.spi_miso),
    .o_half_tick  (w_half_tick),
    .o_sck        (spi.spi_clk),
    .o_bits_done  (w_bits_done),
    .o_frame_done (w_frame_done),
    .o_frame      (w_frame)
  );

  assign w_tick      = (r_period == PER_W'(UPDATE_PERIOD - 1));
  assign w_selected  = (r_state == ST_SELECT) || (r_state == ST_SHIFT);
  assign w_parity_ok = frame_parity_ok(w_frame);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= '0;
    end else if (w_tick) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + PER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ch    <= w_ch_next;
      r_gap   <= w_gap_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ch_next    = r_ch;
    w_gap_next   = r_gap;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && i_enable) begin
          w_state_next = ST_SELECT;
          w_ch_next    = '0;
        end
      end
      ST_SELECT: begin
        if (w_half_tick) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_half_tick && w_bits_done) begin
          w_state_next = ST_DESELECT;
          w_gap_next   = '0;
        end
      end
      ST_DESELECT: begin
        if (w_half_tick) begin
          if (r_gap != GAP_W'(CS_GAP - 1)) begin
            w_gap_next = r_gap + GAP_W'(1);
          end else if (r_ch == CH_W'(NUM_CH - 1)) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_SELECT;
            w_ch_next    = r_ch + CH_W'(1);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A tick that finds a sweep still running is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_tick && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end else if (i_clear_flags) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_overrun = r_overrun;
  assign spi.spi_cs = w_cs;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic                 w_hit;
      logic [CURRENT_W-1:0] r_current;
      logic [FRAME_W-1:0]   r_status;
      logic                 r_current_valid, r_status_valid, r_parity_err;

      assign w_cs[gi] = ~(w_selected && (r_ch == CH_W'(gi)));
      assign w_hit    = w_frame_done && (r_ch == CH_W'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_current       <= '0;
          r_status        <= '0;
          r_current_valid <= 1'b0;
          r_status_valid  <= 1'b0;
          r_parity_err    <= 1'b0;
        end else begin
          r_current_valid <= 1'b0;
          r_status_valid  <= 1'b0;
          if (w_hit && w_parity_ok && !w_frame[FRAME_TYPE_BIT]) begin
            r_current       <= decode_current(w_frame, SIGNED_OUT != 0);
            r_current_valid <= 1'b1;
          end
          if (w_hit && w_parity_ok && w_frame[FRAME_TYPE_BIT]) begin
            r_status       <= w_frame;
            r_status_valid <= 1'b1;
          end
          if (w_hit && !w_parity_ok) begin
            r_parity_err <= 1'b1;
          end else if (i_clear_flags) begin
            r_parity_err <= 1'b0;
          end
        end
      end

      assign o_current[13*gi +: 13]     = r_current;
      assign o_status_word[16*gi +: 16] = r_status;
      assign o_current_valid[gi]        = r_current_valid;
      assign o_status_valid[gi]         = r_status_valid;
      assign o_parity_err[gi]           = r_parity_err;
    end
  endgenerate

endmodule

// File: tb/tb_tli4970_array.sv
// Two-channel bench: a sensor model answers each chip select with a fixed
// frame; a scoreboard queue is matched against every valid pulse.
module tb_tli4970_array;
  import tli4970_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en_a = 1'b1, clr_a = 1'b0, clr_b = 1'b0;
  logic [25:0] cur_a, cur_b;
  logic [1:0]  cv_a, cv_b, sv_a, sv_b, perr_a, perr_b;
  logic [31:0] stat_a, stat_b;
  logic        ovr_a, ovr_b;

  tli4970_if #(.NUM_CH(2)) ifc_a ();
  tli4970_if #(.NUM_CH(2)) ifc_b ();

  tli4970_array #(.NUM_CH(2), .CLK_DIV(4), .UPDATE_PERIOD(400), .CS_GAP(2), .SIGNED_OUT(1)) dut_a (
    .clk(clk), .rst(rst), .i_enable(en_a), .i_clear_flags(clr_a), .spi(ifc_a),
    .o_current(cur_a), .o_current_valid(cv_a), .o_status_word(stat_a),
    .o_status_valid(sv_a), .o_parity_err(perr_a), .o_overrun(ovr_a));

  // Period deliberately shorter than one sweep (280 clk) to provoke overrun.
  tli4970_array #(.NUM_CH(2), .CLK_DIV(4), .UPDATE_PERIOD(200), .CS_GAP(2), .SIGNED_OUT(1)) dut_b (
    .clk(clk), .rst(rst), .i_enable(1'b1), .i_clear_flags(clr_b), .spi(ifc_b),
    .o_current(cur_b), .o_current_valid(cv_b), .o_status_word(stat_b),
    .o_status_valid(sv_b), .o_parity_err(perr_b), .o_overrun(ovr_b));

  assign ifc_b.spi_miso = 1'b0;

  // Sensor model: loads its frame when selected, shifts after each SCK fall.
  logic [15:0] sens_frame [2];
  logic [15:0] sens_sr = 16'h0000;
  logic [1:0]  sens_last_cs = 2'b11;
  assign ifc_a.spi_miso = sens_sr[15];

  always @(ifc_a.spi_cs or negedge ifc_a.spi_clk) begin
    if (ifc_a.spi_cs !== sens_last_cs) begin
      sens_last_cs = ifc_a.spi_cs;
      for (int i = 0; i < 2; i++)
        if (ifc_a.spi_cs[i] === 1'b0) sens_sr = sens_frame[i];
    end else if (ifc_a.spi_clk === 1'b0) begin
      sens_sr = {sens_sr[14:0], 1'b0};
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_status;
    int          ch;
    logic [15:0] val;
  } exp_t;
  exp_t sb_q[$];

  task automatic push_exp(input bit is_status, input int ch, input logic [15:0] val);
    exp_t e;
    e.is_status = is_status;
    e.ch = ch;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input bit is_status, input int ch, input logic [15:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected kind=%0d ch=%0d actual=%h required=none", is_status, ch, act);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("sb_kind_ch%0d", ch), {30'd0, is_status, 1'b0} | ch,
            {30'd0, e.is_status, 1'b0} | e.ch);
      check($sformatf("sb_value_ch%0d", ch), {16'd0, act}, {16'd0, e.val});
      $display("txn kind=%0d ch=%0d value=%h", is_status, ch, act);
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (cv_a[c] === 1'b1) sb_pop(1'b0, c, {3'b000, cur_a[13*c +: 13]});
      if (sv_a[c] === 1'b1) sb_pop(1'b1, c, stat_a[16*c +: 16]);
    end
  end

  int viol_cnt = 0;
  always @(negedge clk) begin
    if (rst === 1'b0)
      if ($countones(~ifc_a.spi_cs) > 1 || (ifc_a.spi_clk && (&ifc_a.spi_cs))) viol_cnt++;
  end

  int b_cs0_falls = 0;
  always @(negedge ifc_b.spi_cs[0]) b_cs0_falls++;

  int c_cs0_fall, c_rise1, c_rise2, c_last_fall, c_cs0_rise, c_cs1_fall;

  // Follows one sweep cycle by cycle, recording the cycle of each pin event.
  task automatic watch_sweep(input int budget, output bit ok);
    logic [1:0] pcs;
    logic psck;
    bit started, cs0_done;
    int n_rise;
    ok = 0; started = 0; cs0_done = 0; n_rise = 0;
    pcs = ifc_a.spi_cs; psck = ifc_a.spi_clk;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (pcs[0] && !ifc_a.spi_cs[0] && !started) begin started = 1; c_cs0_fall = cyc; end
      if (started && !psck && ifc_a.spi_clk) begin
        n_rise++;
        if (n_rise == 1) c_rise1 = cyc;
        if (n_rise == 2) c_rise2 = cyc;
      end
      if (started && !cs0_done && psck && !ifc_a.spi_clk) c_last_fall = cyc;
      if (started && !pcs[0] && ifc_a.spi_cs[0]) begin cs0_done = 1; c_cs0_rise = cyc; end
      if (started && pcs[1] && !ifc_a.spi_cs[1]) c_cs1_fall = cyc;
      if (started && !pcs[1] && ifc_a.spi_cs[1]) begin ok = 1; break; end
      pcs = ifc_a.spi_cs; psck = ifc_a.spi_clk;
    end
  endtask

  task automatic wait_cs(input int ch, input logic lvl, input int budget, output bit ok);
    ok = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (ifc_a.spi_cs[ch] === lvl) begin ok = 1; break; end
    end
  endtask

  initial begin
    bit ok;
    int n, low_cycles, b_base;
    logic psck;
    sens_frame[0] = 16'h1064;
    sens_frame[1] = 16'h0FFF;
    push_exp(0, 0, 16'h0064);
    push_exp(0, 1, 16'h1FFF);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs", {30'd0, ifc_a.spi_cs}, 32'h3);
    check("rst_sck", {31'd0, ifc_a.spi_clk}, 32'h0);
    check("rst_current", {6'd0, cur_a}, 32'h0);
    check("rst_status", stat_a, 32'h0);
    check("rst_valids", {28'd0, cv_a, sv_a}, 32'h0);
    check("rst_flags", {29'd0, perr_a, ovr_a}, 32'h0);

    fork
      begin
        b_base = b_cs0_falls;
        repeat (300) @(negedge clk);
        check("b_overrun_before_2nd_tick", {31'd0, ovr_b}, 32'h0);
        repeat (150) @(negedge clk);
        check("b_overrun_set", {31'd0, ovr_b}, 32'h1);
        repeat (50) @(negedge clk);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        @(negedge clk);
        check("b_overrun_cleared", {31'd0, ovr_b}, 32'h0);
        repeat (400) @(negedge clk);
        check("b_sweep_starts", b_cs0_falls - b_base, 32'd2);
      end
      begin
        watch_sweep(800, ok);
        check("sweep1_done", {31'd0, ok}, 32'h1);
        check("t_cs0_to_first_rise", c_rise1 - c_cs0_fall, 32'd4);
        check("t_sck_period", c_rise2 - c_rise1, 32'd8);
        check("t_last_fall_to_cs0_rise", c_cs0_rise - c_last_fall, 32'd4);
        check("t_cs_gap", c_cs1_fall - c_cs0_rise, 32'd8);
        repeat (3) @(negedge clk);
        check("sweep1_drained", sb_q.size(), 32'd0);

        sens_frame[0] = 16'h0000;
        sens_frame[1] = 16'hC003;
        push_exp(0, 0, 16'h1000);
        push_exp(1, 1, 16'hC003);
        watch_sweep(800, ok);
        check("sweep2_done", {31'd0, ok}, 32'h1);
        repeat (3) @(negedge clk);
        check("sweep2_drained", sb_q.size(), 32'd0);
        check("status_keeps_current1", {19'd0, cur_a[25:13]}, 32'h1FFF);
        check("no_parity_err", {30'd0, perr_a}, 32'h0);

        sens_frame[0] = 16'h5FFF;
        sens_frame[1] = 16'h8005;
        push_exp(0, 0, 16'h0FFF);
        watch_sweep(800, ok);
        check("sweep3_done", {31'd0, ok}, 32'h1);
        repeat (3) @(negedge clk);
        check("sweep3_drained", sb_q.size(), 32'd0);
        check("parity_err_ch1", {30'd0, perr_a}, 32'h2);
        check("bad_frame_keeps_status1", {16'd0, stat_a[31:16]}, 32'hC003);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("parity_err_cleared", {30'd0, perr_a}, 32'h0);

        sens_frame[0] = 16'h1064;
        sens_frame[1] = 16'h2001;
        push_exp(0, 0, 16'h0064);
        push_exp(0, 1, 16'h1001);
        wait_cs(0, 1'b0, 800, ok);
        check("sweep4_start", {31'd0, ok}, 32'h1);
        en_a = 1'b0;
        wait_cs(1, 1'b0, 400, ok);
        check("sweep4_ch1_select", {31'd0, ok}, 32'h1);
        wait_cs(1, 1'b1, 400, ok);
        check("sweep4_ch1_release", {31'd0, ok}, 32'h1);
        repeat (3) @(negedge clk);
        check("sweep4_drained", sb_q.size(), 32'd0);
        low_cycles = 0;
        repeat (500) begin
          @(negedge clk);
          if (ifc_a.spi_cs !== 2'b11) low_cycles++;
        end
        check("disabled_no_cs_activity", low_cycles, 32'd0);

        en_a = 1'b1;
        sens_frame[0] = 16'h1064;
        sens_frame[1] = 16'h0FFF;
        wait_cs(0, 1'b0, 800, ok);
        check("sweep5_start", {31'd0, ok}, 32'h1);
        n = 0;
        psck = ifc_a.spi_clk;
        for (int cyc = 0; cyc < 200 && n < 8; cyc++) begin
          @(negedge clk);
          if (!psck && ifc_a.spi_clk) n++;
          psck = ifc_a.spi_clk;
        end
        check("reached_bit7", n, 32'd8);
        #2 rst = 1'b1;
        #1;
        check("midframe_rst_cs", {30'd0, ifc_a.spi_cs}, 32'h3);
        check("midframe_rst_sck", {31'd0, ifc_a.spi_clk}, 32'h0);
        check("midframe_rst_current", {6'd0, cur_a}, 32'h0);
        check("midframe_rst_valid", {30'd0, cv_a}, 32'h0);
        en_a = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("after_rst_current", {6'd0, cur_a}, 32'h0);
        check("final_drained", sb_q.size(), 32'd0);
        check("one_cs_and_sck_gating", viol_cnt, 32'd0);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
